// File: rtl/booth_mul_sched_pkg.sv
// Shared types and helpers for the Booth multiplier scheduler.
// Holds the scheduler FSM state type and a constant clog2 helper.
package booth_mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_mul_sched_core.sv
// Sequential radix-2 Booth multiplier core, one bit per cycle.
// The accumulator carries two guard bits so -2^(N-1) operands cannot overflow.
module booth_core
    import booth_mul_sched_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           start,
    input  logic [N-1:0]   op1,
    input  logic [N-1:0]   op2,
    output logic           busy,
    output logic [2*N-1:0] prod
);

    localparam int CW = clog2(N + 1);

    logic [N+1:0]  acc;
    logic [N+1:0]  mcand;
    logic [N+1:0]  sum;
    logic [N-1:0]  mplr;
    logic          q1;
    logic [CW-1:0] cnt;

    // Booth recoding of the current multiplier bit pair
    always_comb begin
        sum = acc;
        unique case ({mplr[0], q1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
    end

    // Load on start, then add/subtract and shift right for N steps;
    // busy drops one cycle after the last step, once the product is settled
    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= '0;
            mcand <= {{2{op1[N-1]}}, op1};
            mplr  <= op2;
            q1    <= 1'b0;
            cnt   <= CW'(N);
            busy  <= 1'b1;
        end else if (busy) begin
            if (cnt != '0) begin
                acc  <= {sum[N+1], sum[N+1:1]};
                mplr <= {sum[0], mplr[N-1:1]};
                q1   <= mplr[0];
                cnt  <= cnt - 1'b1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign prod = {acc[N-1:0], mplr};

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one sequential Booth core among NREQ requesters.
// One operation in flight: grant in IDLE, start core in LOAD, count in RUN, hold in DONE.
module booth_mul_sched
    import booth_mul_sched_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*N-1:0]        req_op1,
    input  logic [NREQ*N-1:0]        req_op2,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [clog2(NREQ)-1:0]   rsp_id,
    output logic [2*N-1:0]           rsp_prod
);

    localparam int IDW = clog2(NREQ);
    localparam int CW  = clog2(N + 1);

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] rr_next;
    logic           found;
    logic           accept;
    int             idx;

    logic [N-1:0]   op1;
    logic [N-1:0]   op2;
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
    logic           start;

    logic           core_busy;
    logic [2*N-1:0] core_prod;

    // First valid requester at or above rr_ptr, wrapping modulo NREQ
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = idx[IDW-1:0];
            end
        end
    end

    assign req_ready = (state == IDLE && found) ? (NREQ'(1) << gnt) : '0;
    assign accept    = |(req_valid & req_ready);
    assign rr_next   = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;

    // Scheduler FSM with registered start and response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            cnt       <= '0;
            start     <= 1'b0;
            op1       <= '0;
            op2       <= '0;
            id        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op1    <= req_op1[gnt*N +: N];
                        op2    <= req_op2[gnt*N +: N];
                        id     <= gnt;
                        rr_ptr <= rr_next;
                        start  <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    start <= 1'b0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (cnt == CW'(N)) begin
                        rsp_prod  <= core_prod;
                        rsp_id    <= id;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The core must stay busy for the whole RUN phase
    assert property (@(posedge clk) disable iff (!rst_n)
        (state == RUN) |-> core_busy);

    booth_core #(
        .N(N)
    ) u_core (
        .clk  (clk),
        .start(start),
        .op1  (op1),
        .op2  (op2),
        .busy (core_busy),
        .prod (core_prod)
    );

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed and random checks for booth_mul_sched with N=8, NREQ=4.
// Expected products and latencies are hand-computed or taken from a signed multiply model.
module tb_booth_mul_sched;
    import booth_mul_sched_pkg::*;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int LAT  = N + 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_op1;
    logic [NREQ*N-1:0] req_op2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [2*N-1:0]    rsp_prod;

    int n_chk;
    int n_fail;

    typedef struct {
        int         r;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[10];

    booth_mul_sched #(
        .N(N),
        .NREQ(NREQ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op1  (req_op1),
        .req_op2  (req_op2),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_prod (rsp_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous checks: one-hot ready, core busy during RUN
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
            if (dut.state == RUN) begin
                chk("busy_in_run", 64'(dut.core_busy), 64'd1);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int r);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready[r]) break;
            @(posedge clk);
        end
        chk("grant", 64'(req_ready), 64'(4'b0001 << r));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(LAT));
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
    endtask

    task automatic run_op(input int r, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] p);
        int lat;
        req_op1[r*N +: N] = a;
        req_op2[r*N +: N] = b;
        req_valid = NREQ'(1) << r;
        wait_grant(r);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(lat);
        chk("prod", 64'(rsp_prod), 64'(p));
        chk("id", 64'(rsp_id), 64'(r));
        consume();
    endtask

    initial begin
        int lat;
        int saw;
        logic [7:0] a;
        logic [7:0] b;
        logic signed [15:0] p;
        int r;

        n_chk  = 0;
        n_fail = 0;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        rsp_ready = 1'b0;

        vecs[0] = '{0, 8'h03, 8'hFE, 16'hFFFA};
        vecs[1] = '{1, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{2, 8'h7F, 8'h80, 16'hC080};
        vecs[3] = '{3, 8'h00, 8'hFF, 16'h0000};
        vecs[4] = '{0, 8'hFF, 8'hFF, 16'h0001};
        vecs[5] = '{1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[6] = '{2, 8'h80, 8'h01, 16'hFF80};
        vecs[7] = '{3, 8'h19, 8'hF9, 16'hFF51};
        vecs[8] = '{0, 8'h9C, 8'h64, 16'hD8F0};
        vecs[9] = '{1, 8'h55, 8'h03, 16'h00FF};

        do_reset();
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_prod", 64'(rsp_prod), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Fair grant order from reset with all requesters valid
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_op1[i*N +: N] = 8'(i + 1);
            req_op2[i*N +: N] = 8'd2;
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            @(posedge clk);
            #1;
            wait_rsp(lat);
            chk("rr_id", 64'(rsp_id), 64'(k % 4));
            chk("rr_prod", 64'(rsp_prod), 64'((k % 4 + 1) * 2));
            if (k == 4) req_valid = '0;
            consume();
        end

        // Backpressure in DONE; rr_ptr is 1 here, so only req2 is offered first
        req_op1[2*N +: N] = 8'd5;
        req_op2[2*N +: N] = 8'd5;
        req_valid = 4'b0100;
        wait_grant(2);
        @(posedge clk);
        #1 req_valid = '1;
        wait_rsp(lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_prod", 64'(rsp_prod), 64'h0019);
            chk("bp_id", 64'(rsp_id), 64'd2);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("bp_release", 64'(rsp_valid), 64'd0);
        chk("bp_idle_grant", 64'(req_ready), 64'b1000);
        req_valid = '0;

        // Reset in RUN cycle 4
        req_op1[1*N +: N] = 8'hFD;
        req_op2[1*N +: N] = 8'h07;
        req_valid = 4'b0010;
        wait_grant(1);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mr_valid", 64'(rsp_valid), 64'd0);
        chk("mr_id", 64'(rsp_id), 64'd0);
        chk("mr_prod", 64'(rsp_prod), 64'd0);
        chk("mr_ready", 64'(req_ready), 64'd0);
        saw = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (rsp_valid) saw = 1;
        end
        chk("mr_no_stale", 64'(saw), 64'd0);
        run_op(1, 8'hFD, 8'h07, 16'hFFEB);

        // Random operands from random requesters
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, NREQ - 1));
            a = 8'($urandom);
            b = 8'($urandom);
            p = $signed(a) * $signed(b);
            run_op(r, a, b, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
